lif_potential_unit: RTL and testbench

Leaky integrate-and-fire potential stage placed directly downstream of the per-neuron synaptic weight accumulator (`mac`). Once per timestep it accepts that neuron's accumulated IEEE-754 single-precision weight sum and adds it to the stored membrane potential. It then subtracts a constant leak, clamps the result at the resting level, and compares it against the firing threshold. On a fire it emits a spike carrying the neuron's 12-bit address toward the NoC injection port and resets the potential.

---
 rtl/snn_params_pkg.sv | 23 ++
 rtl/Addition_Subtraction.sv | 87 ++++++++
 rtl/float_compare_ge.sv | 30 +++
 rtl/lif_potential_unit.sv | 140 ++++++++++++++
 tb/tb_lif_potential_unit.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/snn_params_pkg.sv
// snn_params: shared float32 constants, address width and LIF FSM state encoding.
// Rev 1.0
`default_nettype none

package snn_params;

    localparam logic [31:0] FP_ZERO           = 32'h0000_0000;
    localparam logic [31:0] FP_ONE            = 32'h3F80_0000;
    localparam logic [31:0] FP_LEAK_DEFAULT   = 32'h3E00_0000;
    localparam logic [31:0] FP_THRESH_DEFAULT = FP_ONE;
    localparam int          ADDR_W            = 12;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADD   = 3'd1,
        ST_LEAK  = 3'd2,
        ST_CHECK = 3'd3,
        ST_FIRE  = 3'd4
    } lif_state_t;

endpackage

`default_nettype wire

// File: rtl/Addition_Subtraction.sv
// Addition_Subtraction: float32 add/sub, round-to-nearest-even, subnormals flushed to zero.
// Rev 1.0
`default_nettype none

module Addition_Subtraction (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    output logic [31:0] result,
    output logic        exception
);

    logic [30:0] mag_a, mag_b, mag_l, mag_s;
    logic        sign_b, sign_l, sign_s, swap, eff_sub, sticky, round_up;
    logic [7:0]  exp_l, exp_s, shift;
    logic [23:0] man_l, man_s;
    logic [26:0] ext_s, aligned, norm;
    logic [27:0] sum;
    logic [4:0]  lz;
    logic [9:0]  exp_n, exp_r;
    logic [24:0] mant;
    logic [22:0] frac;

    always_comb begin
        // subnormal operands are treated as zero magnitude
        mag_a   = (a[30:23] == 8'd0) ? 31'd0 : a[30:0];
        mag_b   = (b[30:23] == 8'd0) ? 31'd0 : b[30:0];
        sign_b  = b[31] ^ sub;
        swap    = (mag_b > mag_a);
        sign_l  = swap ? sign_b : a[31];
        sign_s  = swap ? a[31] : sign_b;
        mag_l   = swap ? mag_b : mag_a;
        mag_s   = swap ? mag_a : mag_b;
        exp_l   = mag_l[30:23];
        exp_s   = mag_s[30:23];
        man_l   = {(exp_l != 8'd0), mag_l[22:0]};
        man_s   = {(exp_s != 8'd0), mag_s[22:0]};
        shift   = exp_l - exp_s;
        ext_s   = {man_s, 3'b000};
        if (shift >= 8'd27) begin
            aligned = 27'd0;
            sticky  = |man_s;
        end else begin
            aligned = ext_s >> shift;
            sticky  = |(ext_s & ((27'd1 << shift) - 27'd1));
        end
        aligned[0] = aligned[0] | sticky;
        eff_sub = sign_l ^ sign_s;
        sum     = eff_sub ? ({1'b0, man_l, 3'b000} - {1'b0, aligned})
                          : ({1'b0, man_l, 3'b000} + {1'b0, aligned});

        lz = 5'd0;
        for (int i = 0; i < 27; i++) begin
            if (sum[i]) lz = 5'(26 - i);
        end

        if (sum[27]) begin
            norm  = {sum[27:2], sum[1] | sum[0]};
            exp_n = {2'b00, exp_l} + 10'd1;
        end else begin
            norm  = sum[26:0] << lz;
            exp_n = {2'b00, exp_l} - {5'd0, lz};
        end

        round_up = norm[2] & (norm[3] | norm[1] | norm[0]);
        mant     = {1'b0, norm[26:3]} + {24'd0, round_up};
        exp_r    = exp_n + {9'd0, mant[24]};
        frac     = mant[24] ? mant[23:1] : mant[22:0];

        exception = 1'b0;
        result    = {sign_l, exp_r[7:0], frac};
        if ((a[30:23] == 8'hFF) || (b[30:23] == 8'hFF)) begin
            exception = 1'b1;
            result    = 32'h7FC0_0000;
        end else if (sum == 28'd0) begin
            result = {sign_l & sign_s, 31'd0};
        end else if (!exp_r[9] && (exp_r >= 10'd255)) begin
            exception = 1'b1;
            result    = {sign_l, 8'hFF, 23'd0};
        end else if (exp_r[9] || (exp_r == 10'd0)) begin
            result = {sign_l, 31'd0};
        end
    end

endmodule

`default_nettype wire

// File: rtl/float_compare_ge.sv
// float_compare_ge: combinational float32 a >= b, sign-magnitude order, +0 == -0.
// Rev 1.0
`default_nettype none

module float_compare_ge (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        ge
);

    logic a_zero;
    logic b_zero;

    always_comb begin
        a_zero = (a[30:0] == 31'd0);
        b_zero = (b[30:0] == 31'd0);
        if (a_zero && b_zero) begin
            ge = 1'b1;
        end else if (a[31] != b[31]) begin
            ge = b[31];
        end else if (!a[31]) begin
            ge = (a[30:0] >= b[30:0]);
        end else begin
            ge = (a[30:0] <= b[30:0]);
        end
    end

endmodule

`default_nettype wire

// File: rtl/lif_potential_unit.sv
// lif_potential_unit: per-neuron leaky integrate-and-fire stage with spike handshake.
// Rev 1.0
`default_nettype none

module lif_potential_unit
    import snn_params::*;
#(
    parameter logic [31:0] V_THRESH = FP_THRESH_DEFAULT,
    parameter logic [31:0] V_RESET  = FP_ZERO,
    parameter logic [31:0] V_REST   = FP_ZERO,
    parameter logic [31:0] V_LEAK   = FP_LEAK_DEFAULT
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [ADDR_W-1:0] neuron_address,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_weight,
    output logic              spike_valid,
    input  logic              spike_ready,
    output logic [ADDR_W-1:0] spike_address,
    output logic [31:0]       potential,
    output logic              error
);

    lif_state_t  state, next_state;
    logic [31:0] operand;
    logic        step_exc;
    logic [31:0] add_b;
    logic        add_sub;
    logic [31:0] add_result;
    logic        add_exc;
    logic        above_rest;
    logic        above_thresh;
    logic        fire;

    // one adder shared: ADD uses the latched operand, LEAK subtracts the leak constant
    assign add_b   = (state == ST_LEAK) ? V_LEAK : operand;
    assign add_sub = (state == ST_LEAK);

    Addition_Subtraction u_adder (
        .a         (potential),
        .b         (add_b),
        .sub       (add_sub),
        .result    (add_result),
        .exception (add_exc)
    );

    float_compare_ge u_rest_cmp (
        .a  (add_result),
        .b  (V_REST),
        .ge (above_rest)
    );

    float_compare_ge u_thresh_cmp (
        .a  (potential),
        .b  (V_THRESH),
        .ge (above_thresh)
    );

    assign in_ready = (state == ST_IDLE);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= ST_IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        fire       = 1'b0;
        case (state)
            ST_IDLE:  if (in_valid) next_state = ST_ADD;
            ST_ADD:   next_state = ST_LEAK;
            ST_LEAK:  next_state = ST_CHECK;
            ST_CHECK: begin
                fire       = !step_exc && above_thresh;
                next_state = fire ? ST_FIRE : ST_IDLE;
            end
            ST_FIRE:  if (spike_ready) next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            operand       <= 32'd0;
            potential     <= V_RESET;
            spike_valid   <= 1'b0;
            spike_address <= '0;
            error         <= 1'b0;
            step_exc      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        operand  <= in_weight;
                        step_exc <= 1'b0;
                    end
                end
                ST_ADD: begin
                    if (add_exc) begin
                        potential <= V_RESET;
                        error     <= 1'b1;
                        step_exc  <= 1'b1;
                    end else begin
                        potential <= add_result;
                    end
                end
                ST_LEAK: begin
                    // a faulted timestep keeps the reset potential through the leak slot
                    if (step_exc) begin
                        potential <= V_RESET;
                    end else if (add_exc) begin
                        potential <= V_RESET;
                        error     <= 1'b1;
                        step_exc  <= 1'b1;
                    end else if (!above_rest) begin
                        potential <= V_REST;
                    end else begin
                        potential <= add_result;
                    end
                end
                ST_CHECK: begin
                    if (fire) begin
                        potential     <= V_RESET;
                        spike_valid   <= 1'b1;
                        spike_address <= neuron_address;
                    end
                end
                ST_FIRE: begin
                    if (spike_ready) spike_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lif_potential_unit.sv
// tb_lif_potential_unit: randomized LIF timesteps checked against a real-arithmetic model.
// Rev 1.0
`default_nettype none

module tb_lif_potential_unit;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic [11:0] neuron_address;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_weight;
    logic        spike_valid;
    logic        spike_ready;
    logic [11:0] spike_address;
    logic [31:0] potential;
    logic        error;

    lif_potential_unit dut (
        .CLK            (CLK),
        .RESET_N        (RESET_N),
        .neuron_address (neuron_address),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_weight      (in_weight),
        .spike_valid    (spike_valid),
        .spike_ready    (spike_ready),
        .spike_address  (spike_address),
        .potential      (potential),
        .error          (error)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // expected outputs after the most recent edge, plus the model's stored state
    logic        chk_en = 1'b0;
    logic        exp_ready, exp_valid, exp_err;
    logic [11:0] exp_addr;
    logic [31:0] exp_pot;
    logic [31:0] m_pot;
    logic        m_err;
    logic [11:0] m_addr;
    bit          last_spk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic real f2r(input logic [31:0] f);
        if (f[30:23] == 8'd0) return 0.0;
        return $bitstoreal({f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0});
    endfunction

    // nearest-even rounding of a double to float32; bit 32 flags overflow
    function automatic logic [32:0] r2f(input real r);
        logic [63:0] d;
        int          e;
        logic [23:0] m;
        logic [28:0] rem;
        bit          up;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {1'b0, d[63], 31'd0};
        e   = int'(d[62:52]) - 896;
        m   = {1'b0, d[51:29]};
        rem = d[28:0];
        up  = (rem > 29'h1000_0000) || ((rem == 29'h1000_0000) && d[29]);
        m   = m + {23'd0, up};
        if (m[23]) begin
            e = e + 1;
            m = 24'd0;
        end
        if (e >= 255) return {1'b1, d[63], 8'hFF, 23'd0};
        if (e <= 0)   return {1'b0, d[63], 31'd0};
        return {1'b0, d[63], 8'(e), m[22:0]};
    endfunction

    function automatic logic [32:0] fadd(input logic [31:0] a, input logic [31:0] b);
        if ((a[30:23] == 8'hFF) || (b[30:23] == 8'hFF)) return {1'b1, 32'h7FC0_0000};
        return r2f(f2r(a) + f2r(b));
    endfunction

    always @(posedge CLK) begin
        #1;
        if (chk_en) begin
            chk("in_ready",      {31'd0, in_ready},      {31'd0, exp_ready});
            chk("spike_valid",   {31'd0, spike_valid},   {31'd0, exp_valid});
            chk("spike_address", {20'd0, spike_address}, {20'd0, exp_addr});
            chk("potential",     potential,              exp_pot);
            chk("error",         {31'd0, error},         {31'd0, exp_err});
        end
    end

    task automatic junk();
        in_valid  = 1'($urandom);
        in_weight = $urandom;
    endtask

    // one timestep: accept w, then hold spike_ready low for 'hold' cycles if it fires
    task automatic step(input logic [31:0] w, input int hold);
        logic [32:0] r1, r2;
        logic [31:0] p1, p2, p3;
        bit          e1, e2, spk;
        r1 = fadd(m_pot, w);
        e1 = r1[32];
        p1 = e1 ? 32'd0 : r1[31:0];
        e2 = 1'b0;
        p2 = 32'd0;
        if (!e1) begin
            r2 = fadd(p1, 32'hBE00_0000);
            e2 = r2[32];
            p2 = e2 ? 32'd0 : r2[31:0];
            if (!e2 && (f2r(p2) < 0.0)) p2 = 32'd0;
        end
        spk = !e1 && !e2 && (f2r(p2) >= 1.0);
        p3  = spk ? 32'd0 : p2;

        @(negedge CLK);
        in_valid    = 1'b1;
        in_weight   = w;
        spike_ready = 1'($urandom);
        @(posedge CLK);
        exp_ready = 1'b0;
        @(negedge CLK); junk();
        @(posedge CLK);
        exp_pot = p1;
        exp_err = m_err | e1;
        @(negedge CLK); junk();
        @(posedge CLK);
        exp_pot = p2;
        exp_err = m_err | e1 | e2;
        @(negedge CLK); junk();
        @(posedge CLK);
        exp_pot   = p3;
        exp_valid = spk;
        exp_ready = !spk;
        if (spk) exp_addr = neuron_address;
        if (spk) begin
            for (int k = 0; k < hold; k++) begin
                @(negedge CLK); junk(); spike_ready = 1'b0;
                @(posedge CLK);
            end
            @(negedge CLK); junk(); spike_ready = 1'b1;
            @(posedge CLK);
            exp_valid = 1'b0;
            exp_ready = 1'b1;
        end
        m_pot    = p3;
        m_err    = exp_err;
        m_addr   = exp_addr;
        last_spk = spk;
    endtask

    task automatic model_reset();
        m_pot     = 32'd0;
        m_err     = 1'b0;
        m_addr    = 12'd0;
        exp_pot   = 32'd0;
        exp_err   = 1'b0;
        exp_addr  = 12'd0;
        exp_valid = 1'b0;
        exp_ready = 1'b1;
    endtask

    initial begin
        RESET_N        = 1'b0;
        in_valid       = 1'b0;
        in_weight      = 32'd0;
        spike_ready    = 1'b0;
        neuron_address = 12'hA5C;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_in_ready",   {31'd0, in_ready},      32'd1);
        chk("rst_spike",      {31'd0, spike_valid},   32'd0);
        chk("rst_addr",       {20'd0, spike_address}, 32'd0);
        chk("rst_potential",  potential,              32'd0);
        chk("rst_error",      {31'd0, error},         32'd0);
        @(negedge CLK);
        RESET_N = 1'b1;
        chk_en  = 1'b1;

        step(32'h3F00_0000, 0); #1;
        chk("pin_pot_0p375",   potential, 32'h3EC0_0000);
        chk("pin_model_0p375", m_pot,     32'h3EC0_0000);
        step(32'h3F40_0000, 0); #1;
        chk("pin_spike_1p0", {31'd0, last_spk},      32'd1);
        chk("pin_spike_addr",{20'd0, spike_address}, 32'h0000_0A5C);
        chk("pin_pot_reset", potential,              32'd0);
        step(32'hBF80_0000, 0); #1;
        chk("pin_clamp_rest", potential, 32'd0);
        chk("pin_clamp_nospk", {31'd0, last_spk}, 32'd0);
        step(32'h0000_0000, 0); #1;
        chk("pin_zero_step", potential, 32'd0);
        step(32'h3FC0_0000, 5); #1;
        chk("pin_hold_ready", {31'd0, in_ready}, 32'd1);
        step(32'h7F7F_FFFF, 1);
        step(32'h7F7F_FFFF, 0); #1;
        chk("pin_max_noerr", {31'd0, error}, 32'd0);
        step(32'h7F80_0000, 0); #1;
        chk("pin_inf_error", {31'd0, error}, 32'd1);
        chk("pin_inf_pot",   potential,      32'd0);
        step(32'h3F00_0000, 0); #1;
        chk("pin_err_sticky", {31'd0, error}, 32'd1);
        chk("pin_after_err",  potential,      32'h3EC0_0000);

        for (int n = 0; n < 120; n++) begin
            logic [31:0] w;
            logic [7:0]  e;
            e = 8'($urandom_range(117, 128));
            w = {($urandom_range(0, 3) == 0), e, 23'($urandom)};
            step(w, $urandom_range(0, 3));
        end

        // asynchronous reset while a spike is held pending
        @(negedge CLK);
        chk_en      = 1'b0;
        in_valid    = 1'b1;
        in_weight   = 32'h3FC0_0000;
        spike_ready = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        in_valid = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        chk("fire_pending", {31'd0, spike_valid}, 32'd1);
        chk("fire_busy",    {31'd0, in_ready},    32'd0);
        @(negedge CLK);
        #2 RESET_N = 1'b0;
        #1;
        chk("async_spike",  {31'd0, spike_valid}, 32'd0);
        chk("async_pot",    potential,            32'd0);
        chk("async_error",  {31'd0, error},       32'd0);
        chk("async_addr",   {20'd0, spike_address}, 32'd0);
        @(negedge CLK);
        RESET_N = 1'b1;
        #1;
        chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
        model_reset();
        chk_en = 1'b1;
        step(32'h3F00_0000, 0); #1;
        chk("post_rst_pot", potential, 32'h3EC0_0000);

        @(negedge CLK);
        in_valid = 1'b0;
        chk_en   = 1'b0;
        repeat (2) @(posedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
